// File: rtl/vc_arbiter.sv
// vc_arbiter: strict-priority VC0/VC1 read scheduler with VC1 anti-starvation,
//    routing each popped word to D0 or D1 by its MSB.
// Latency: pop (rd) in cycle t -> destination push and data in cycle t+1.
// Backpressure: no pop while either destination is almost full; a word already in flight is still pushed.
// Ports: clk/reset_L (synchronous, active-low); vc*_empty/vc*_data from the VC FIFOs;
//    d*_almost_full from destinations; vc*_rd pop strobes; d*_push/d*_data writes;
//    vc*_grants modulo-256 pop counters.
module vc_arbiter #(
   parameter int BW       = 6,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset_L,
   input  logic          vc0_empty,
   input  logic          vc1_empty,
   input  logic [BW-1:0] vc0_data,
   input  logic [BW-1:0] vc1_data,
   input  logic          d0_almost_full,
   input  logic          d1_almost_full,
   output logic          vc0_rd,
   output logic          vc1_rd,
   output logic          d0_push,
   output logic          d1_push,
   output logic [BW-1:0] d0_data,
   output logic [BW-1:0] d1_data,
   output logic [7:0]    vc0_grants,
   output logic [7:0]    vc1_grants
);

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   logic          ok;
   logic [3:0]    wait_cnt;
   logic          pop_v;
   logic          pop_src;
   logic [BW-1:0] word;
   logic          live;

   // Grant: the destination is not known until the word is read, so both
   // destinations must have room before anything is popped.
   always_comb begin
      ok     = reset_L && !d0_almost_full && !d1_almost_full;
      vc0_rd = ok && !vc0_empty && (vc1_empty || (wait_cnt < MAX_W));
      vc1_rd = ok && !vc1_empty && !vc0_rd;
   end

   // Route stage. A word popped just before a reset edge is dropped: the push
   // is masked by reset_L so nothing leaves the block while reset is asserted.
   always_comb begin
      word    = pop_src ? vc1_data : vc0_data;
      live    = pop_v && reset_L;
      d0_push = live && !word[BW-1];
      d1_push = live && word[BW-1];
      d0_data = d0_push ? word : '0;
      d1_data = d1_push ? word : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         pop_v      <= 1'b0;
         pop_src    <= 1'b0;
         wait_cnt   <= 4'd0;
         vc0_grants <= 8'd0;
         vc1_grants <= 8'd0;
      end else begin
         pop_v   <= vc0_rd || vc1_rd;
         pop_src <= vc1_rd;

         // Count VC0 wins only while VC1 is actually waiting. VC0 cannot be
         // granted once the count reaches MAX_W while VC1 waits, so the
         // increment saturates naturally; the guard keeps it explicit.
         if (vc1_empty || vc1_rd)
            wait_cnt <= 4'd0;
         else if (vc0_rd && (wait_cnt < MAX_W))
            wait_cnt <= wait_cnt + 4'd1;

         if (vc0_rd)
            vc0_grants <= vc0_grants + 8'd1;
         if (vc1_rd)
            vc1_grants <= vc1_grants + 8'd1;
      end
   end

endmodule
